// File: rtl/uart_mmio_stream_bridge_if.sv
// rtl/uart_mmio_stream_bridge_if.sv - stream and MMIO signal bundle for the UART stream bridge
`timescale 1ns/1ps

interface uart_mmio_stream_bridge_if;
    // TX byte stream from fabric
    logic [7:0]  s_tx_data;
    logic        s_tx_valid;
    logic        s_tx_ready;
    // RX byte stream to fabric
    logic [7:0]  m_rx_data;
    logic        m_rx_valid;
    logic        m_rx_ready;
    // MMIO bus towards uart_top
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] rdata;

    // Bridge side
    modport master (
        input  s_tx_data, s_tx_valid,
        output s_tx_ready,
        output m_rx_data, m_rx_valid,
        input  m_rx_ready,
        output addr, wdata, wr_en, rd_en,
        input  rdata
    );

    // Fabric source/sink and UART register file side
    modport slave (
        output s_tx_data, s_tx_valid,
        input  s_tx_ready,
        input  m_rx_data, m_rx_valid,
        output m_rx_ready,
        input  addr, wdata, wr_en, rd_en,
        output rdata
    );
endinterface

// File: rtl/uart_mmio_stream_bridge.sv
// rtl/uart_mmio_stream_bridge.sv - MMIO master turning byte streams into uart_top register accesses
`timescale 1ns/1ps

module uart_mmio_stream_bridge #(
    parameter logic [3:0]  CTRL_ADDR     = 4'h0,
    parameter logic [3:0]  BAUD_ADDR     = 4'h1,
    parameter logic [3:0]  DATA_ADDR     = 4'h2,
    parameter logic [3:0]  STATUS_ADDR   = 4'h3,
    parameter logic [31:0] CTRL_INIT     = 32'h1,
    parameter logic [15:0] BAUD_DIV_INIT = 16'd27,
    parameter int          TX_FULL_BIT   = 1,
    parameter int          RX_EMPTY_BIT  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    uart_mmio_stream_bridge_if.master bus,
    output logic                      init_done
);

    typedef enum logic [2:0] {
        INIT_BAUD,
        INIT_CTRL,
        POLL,
        POLL_WAIT,
        TX_WR,
        RX_RD,
        RX_WAIT
    } state_t;

    // state_q names the access currently shown on the bus; strobes are
    // registered from the state being entered so they line up with it.
    state_t      state_q, state_d;
    logic        started_q, started_d;
    logic        wr_en_q, wr_en_d;
    logic        rd_en_q, rd_en_d;
    logic        tx_ready_q, tx_ready_d;
    logic [3:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_valid_q, hold_valid_d;
    logic        last_tx_q, last_tx_d;
    logic        init_done_q, init_done_d;

    logic        tx_ok;
    logic        rx_ok;
    logic        rdata_unused;

    // Status decode, meaningful only in POLL_WAIT when rdata carries STATUS
    assign rx_ok        = !bus.rdata[RX_EMPTY_BIT] && !hold_valid_q;
    assign tx_ok        = !bus.rdata[TX_FULL_BIT] && bus.s_tx_valid;
    assign rdata_unused = ^bus.rdata[31:8];

    // Next state, RX holding register and round-robin, then bus strobes for the entered state
    always_comb begin
        state_d      = state_q;
        started_d    = 1'b1;
        wr_en_d      = 1'b0;
        rd_en_d      = 1'b0;
        tx_ready_d   = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        last_tx_d    = last_tx_q;
        init_done_d  = init_done_q;

        if (hold_valid_q && bus.m_rx_ready) begin
            hold_valid_d = 1'b0;
        end

        // The first cycle out of reset keeps the bus quiet and then enters INIT_BAUD
        if (!started_q) begin
            state_d = INIT_BAUD;
        end else begin
            case (state_q)
                INIT_BAUD: state_d = INIT_CTRL;
                INIT_CTRL: begin
                    state_d     = POLL;
                    init_done_d = 1'b1;
                end
                POLL:      state_d = POLL_WAIT;
                POLL_WAIT: begin
                    // RX wins a tie unless it was the side served last
                    if (rx_ok && (!tx_ok || last_tx_q)) begin
                        state_d = RX_RD;
                    end else if (tx_ok) begin
                        state_d = TX_WR;
                    end else begin
                        state_d = POLL;
                    end
                end
                TX_WR: begin
                    last_tx_d = 1'b1;
                    state_d   = POLL;
                end
                RX_RD:     state_d = RX_WAIT;
                RX_WAIT: begin
                    hold_d       = bus.rdata[7:0];
                    hold_valid_d = 1'b1;
                    last_tx_d    = 1'b0;
                    state_d      = POLL;
                end
                default:   state_d = POLL;
            endcase
        end

        case (state_d)
            INIT_BAUD: begin
                wr_en_d = 1'b1;
                addr_d  = BAUD_ADDR;
                wdata_d = {16'b0, BAUD_DIV_INIT};
            end
            INIT_CTRL: begin
                wr_en_d = 1'b1;
                addr_d  = CTRL_ADDR;
                wdata_d = CTRL_INIT;
            end
            POLL: begin
                rd_en_d = 1'b1;
                addr_d  = STATUS_ADDR;
            end
            TX_WR: begin
                wr_en_d    = 1'b1;
                tx_ready_d = 1'b1;
                addr_d     = DATA_ADDR;
                wdata_d    = {24'b0, bus.s_tx_data};
            end
            RX_RD: begin
                rd_en_d = 1'b1;
                addr_d  = DATA_ADDR;
            end
            default: ;
        endcase
    end

    // State and registered outputs; reset drops strobes and discards any held RX byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INIT_BAUD;
            started_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            tx_ready_q   <= 1'b0;
            addr_q       <= 4'h0;
            wdata_q      <= 32'h0;
            hold_q       <= 8'h0;
            hold_valid_q <= 1'b0;
            last_tx_q    <= 1'b1;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            started_q    <= started_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            tx_ready_q   <= tx_ready_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            last_tx_q    <= last_tx_d;
            init_done_q  <= init_done_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.addr       = addr_q;
    assign bus.wdata      = wdata_q;
    assign bus.s_tx_ready = tx_ready_q;
    assign bus.m_rx_data  = hold_q;
    assign bus.m_rx_valid = hold_valid_q;
    assign init_done      = init_done_q;

endmodule

// File: tb/tb_uart_mmio_stream_bridge.sv
// tb/tb_uart_mmio_stream_bridge.sv - self-checking bench for uart_mmio_stream_bridge
`timescale 1ns/1ps

module tb_uart_mmio_stream_bridge;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic init_done;

    uart_mmio_stream_bridge_if bus();

    uart_mmio_stream_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // UART register model and observation state
    bit          tx_full_m = 1'b0;
    byte unsigned rx_fifo[$];
    bit          last_stat_full  = 1'b1;
    bit          last_stat_empty = 1'b1;
    bit          polled_since    = 1'b0;
    int          cyc = 0;
    byte unsigned tx_log[$];
    int          tx_cyc[$];
    byte unsigned rx_log[$];
    bit          acc_wr[$];
    int          status_reads = 0;
    int          data_reads   = 0;
    int          overlap_err  = 0;
    int          full_err     = 0;
    int          empty_err    = 0;
    int          b2b_err      = 0;
    int          ready_err    = 0;

    // Fabric source state
    byte unsigned tx_src[$];
    bit          tx_pop_pending = 1'b0;
    bit          rand_ready = 1'b0;
    bit          rand_full  = 1'b0;

    // Register file of the UART plus protocol monitors, sampled at the active edge
    always @(posedge clk) begin
        cyc++;
        if (bus.wr_en && bus.rd_en) overlap_err++;
        if (bus.rd_en) begin
            if (bus.addr == 4'h3) begin
                bus.rdata <= {29'b0, (rx_fifo.size() == 0), tx_full_m, 1'b0};
                last_stat_full  = tx_full_m;
                last_stat_empty = (rx_fifo.size() == 0);
                polled_since    = 1'b1;
                status_reads++;
            end else if (bus.addr == 4'h2) begin
                if (!polled_since) b2b_err++;
                polled_since = 1'b0;
                if (last_stat_empty) empty_err++;
                if (rx_fifo.size() != 0) bus.rdata <= {24'b0, rx_fifo.pop_front()};
                else bus.rdata <= 32'h0;
                acc_wr.push_back(1'b0);
                data_reads++;
            end else begin
                bus.rdata <= 32'h0;
            end
        end
        if (bus.wr_en && bus.addr == 4'h2) begin
            if (!polled_since) b2b_err++;
            polled_since = 1'b0;
            if (last_stat_full) full_err++;
            if (!bus.s_tx_ready) ready_err++;
            tx_log.push_back(bus.wdata[7:0]);
            tx_cyc.push_back(cyc);
            acc_wr.push_back(1'b1);
        end
        if (bus.s_tx_ready && !(bus.wr_en && bus.addr == 4'h2)) ready_err++;
        if (bus.m_rx_valid && bus.m_rx_ready) rx_log.push_back(bus.m_rx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic load_tx();
        bus.s_tx_valid = (tx_src.size() != 0);
        bus.s_tx_data  = (tx_src.size() != 0) ? tx_src[0] : 8'h00;
    endtask

    // Advance to the next falling edge and update the fabric source/sink
    task automatic step();
        byte unsigned dropped;
        @(negedge clk);
        if (tx_pop_pending) begin
            dropped        = tx_src.pop_front();
            tx_pop_pending = 1'b0;
        end
        load_tx();
        if (bus.s_tx_ready) tx_pop_pending = 1'b1;
        if (rand_ready) bus.m_rx_ready = ($urandom_range(0, 9) < 7);
        if (rand_full) tx_full_m = ($urandom_range(0, 9) < 2);
    endtask

    task automatic check_init_sequence(input string tag);
        step();
        check({tag, "_c1_wr"}, {bus.wr_en, bus.rd_en, bus.addr}, {1'b1, 1'b0, 4'h1});
        check({tag, "_c1_wdata"}, bus.wdata, 32'd27);
        step();
        check({tag, "_c2_wr"}, {bus.wr_en, bus.rd_en, bus.addr, init_done}, {1'b1, 1'b0, 4'h0, 1'b0});
        check({tag, "_c2_wdata"}, bus.wdata, 32'h1);
        step();
        check({tag, "_c3_poll"}, {init_done, bus.wr_en, bus.rd_en, bus.addr}, {1'b1, 1'b0, 1'b1, 4'h3});
    endtask

    initial begin
        int w0, r0, a0, tb0, rb0;
        bit found;
        byte unsigned exp_tx[$];
        byte unsigned exp_rx[$];

        bus.s_tx_valid = 1'b0;
        bus.s_tx_data  = 8'h00;
        bus.m_rx_ready = 1'b0;

        // Reset state
        step();
        step();
        check("rst_strobes", {bus.wr_en, bus.rd_en, bus.s_tx_ready, bus.m_rx_valid, init_done}, 5'b0);
        check("rst_addr", {28'b0, bus.addr}, 32'h0);
        check("rst_wdata", bus.wdata, 32'h0);
        check("rst_rxdata", {24'b0, bus.m_rx_data}, 32'h0);
        rst_n = 1'b1;

        // Configuration writes
        check_init_sequence("init");

        // Two TX bytes against an idle UART
        tx_src.push_back(8'h55);
        tx_src.push_back(8'hA3);
        load_tx();
        repeat (12) step();
        check("tx2_count", tx_log.size(), 2);
        check("tx2_first", {24'b0, tx_log[0]}, 32'h55);
        check("tx2_second", {24'b0, tx_log[1]}, 32'hA3);
        check("tx2_spacing", tx_cyc[1] - tx_cyc[0], 3);
        check("tx2_ready_err", ready_err, 0);

        // TX FIFO full holds off the write
        tx_full_m = 1'b1;
        repeat (3) step();
        w0 = tx_log.size();
        r0 = status_reads;
        tx_src.push_back(8'h3C);
        load_tx();
        repeat (20) step();
        check("full_no_write", tx_log.size(), w0);
        check("full_polling", (status_reads - r0) >= 8, 1);
        check("full_ready_low", ready_err, 0);
        tx_full_m = 1'b0;
        repeat (10) step();
        check("unfull_write", tx_log.size(), w0 + 1);
        check("unfull_data", {24'b0, tx_log[w0]}, 32'h3C);

        // RX holding register backpressure
        r0 = data_reads;
        rx_fifo.push_back(8'h41);
        rx_fifo.push_back(8'h42);
        repeat (30) step();
        check("rxhold_valid", bus.m_rx_valid, 1'b1);
        check("rxhold_data", {24'b0, bus.m_rx_data}, 32'h41);
        check("rxhold_one_read", data_reads - r0, 1);
        bus.m_rx_ready = 1'b1;
        repeat (20) step();
        check("rxdrain_count", rx_log.size(), 2);
        check("rxdrain_first", {24'b0, rx_log[0]}, 32'h41);
        check("rxdrain_second", {24'b0, rx_log[1]}, 32'h42);

        // Both sides ready: accesses alternate, TX first since RX was served last
        a0 = acc_wr.size();
        for (int i = 0; i < 4; i++) begin
            tx_src.push_back(8'(8'h10 + i));
            rx_fifo.push_back(8'(8'h20 + i));
        end
        load_tx();
        repeat (40) step();
        check("alt_count", acc_wr.size() - a0, 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("alt_%0d", i), acc_wr[a0 + i], (i % 2 == 0));
        check("alt_rx_last", {24'b0, rx_log[5]}, 32'h23);
        check("alt_tx_last", {24'b0, tx_log[tx_log.size() - 1]}, 32'h13);

        // Reset while the RX data read is in flight
        bus.m_rx_ready = 1'b0;
        rx_fifo.push_back(8'h99);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (bus.rd_en && bus.addr == 4'h2) found = 1'b1;
        end
        check("midrst_found_rxrd", found, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outputs", {bus.wr_en, bus.rd_en, bus.s_tx_ready, bus.m_rx_valid, init_done}, 5'b0);
        step();
        rst_n = 1'b1;
        check_init_sequence("reinit");

        // After reset RX is preferred on a tie, and the dropped byte never appears
        a0  = acc_wr.size();
        rb0 = rx_log.size();
        tx_src.push_back(8'h77);
        rx_fifo.push_back(8'h66);
        load_tx();
        bus.m_rx_ready = 1'b1;
        repeat (20) step();
        check("postrst_first_rx", acc_wr[a0], 1'b0);
        check("postrst_then_tx", acc_wr[a0 + 1], 1'b1);
        check("postrst_rx_count", rx_log.size() - rb0, 1);
        check("postrst_rx_data", {24'b0, rx_log[rb0]}, 32'h66);

        // Random traffic against the ordering model
        tb0 = tx_log.size();
        rb0 = rx_log.size();
        for (int i = 0; i < 30; i++) begin
            exp_tx.push_back(8'($urandom));
            exp_rx.push_back(8'($urandom));
        end
        for (int i = 0; i < 30; i++) begin
            tx_src.push_back(exp_tx[i]);
            rx_fifo.push_back(exp_rx[i]);
        end
        load_tx();
        rand_ready = 1'b1;
        rand_full  = 1'b1;
        for (int k = 0; k < 4000 && !((tx_log.size() - tb0) >= 30 && (rx_log.size() - rb0) >= 30); k++)
            step();
        rand_ready = 1'b0;
        rand_full  = 1'b0;
        check("rand_done", ((tx_log.size() - tb0) == 30) && ((rx_log.size() - rb0) == 30), 1);
        for (int i = 0; i < 30; i++) begin
            check($sformatf("rand_tx_%0d", i), {24'b0, tx_log[tb0 + i]}, {24'b0, exp_tx[i]});
            check($sformatf("rand_rx_%0d", i), {24'b0, rx_log[rb0 + i]}, {24'b0, exp_rx[i]});
        end

        // Protocol rules over the whole run
        check("no_overlap", overlap_err, 0);
        check("no_write_when_full", full_err, 0);
        check("no_read_when_empty", empty_err, 0);
        check("status_before_data", b2b_err, 0);
        check("ready_only_with_write", ready_err, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_mmio_stream_bridge.md
Name: uart_mmio_stream_bridge

Overview:
- MMIO master that sits directly upstream of uart_top. It drives addr/wdata/wr_en/rd_en and consumes rdata.
- Converts a byte valid/ready TX stream into UART data-register writes.
- Drains the UART RX FIFO into a byte valid/ready RX stream.
- Performs a one-time UART configuration sequence after reset, so fabric logic can use the UART without software.

Parameters:
- CTRL_ADDR, 4'h0, control register address
- BAUD_ADDR, 4'h1, baud divisor register address
- DATA_ADDR, 4'h2, TX write / RX read data register address
- STATUS_ADDR, 4'h3, status register address
- CTRL_INIT, 32'h1, value written to CTRL at init (uart_en=1)
- BAUD_DIV_INIT, 16'd27, divisor written to BAUD at init
- TX_FULL_BIT, 1, STATUS bit index: TX FIFO full
- RX_EMPTY_BIT, 2, STATUS bit index: RX FIFO empty

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_tx_data  in  8  TX byte from fabric
- s_tx_valid  in  1  TX byte valid
- s_tx_ready  out  1  TX byte accepted this cycle
- m_rx_data  out  8  RX byte to fabric
- m_rx_valid  out  1  RX byte valid
- m_rx_ready  in  1  fabric accepts RX byte
- addr  out  4  MMIO register address
- wdata  out  32  MMIO write data
- wr_en  out  1  MMIO write strobe, one cycle
- rd_en  out  1  MMIO read strobe, one cycle
- rdata  in  32  MMIO read data, valid the cycle after rd_en
- init_done  out  1  high once the configuration writes are complete

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0. State = INIT_BAUD. RX holding register empty.
- Strobes: at most one of wr_en/rd_en is high in any cycle. Each strobe lasts exactly one cycle. addr/wdata are held stable while a strobe is high.
- Read latency: rdata is sampled exactly 1 cycle after rd_en.

State machine:
- INIT_BAUD: wr_en=1, addr=BAUD_ADDR, wdata={16'b0,BAUD_DIV_INIT} -> INIT_CTRL.
- INIT_CTRL: wr_en=1, addr=CTRL_ADDR, wdata=CTRL_INIT -> POLL. init_done goes 1 on the next cycle and stays 1 until reset.
- POLL: rd_en=1, addr=STATUS_ADDR -> POLL_WAIT.
- POLL_WAIT: capture tx_full=rdata[TX_FULL_BIT] and rx_empty=rdata[RX_EMPTY_BIT]. Set rx_ok = !rx_empty && holding register empty; tx_ok = !tx_full && s_tx_valid.
  - Both ok: serve the side opposite to the last-served side (round-robin; last-served resets to TX, so RX wins first).
  - One ok: serve that side.
  - Neither ok: -> POLL.
- TX_WR: wr_en=1, addr=DATA_ADDR, wdata={24'b0,s_tx_data}, s_tx_ready=1 in the same cycle. Set last=TX -> POLL.
- RX_RD: rd_en=1, addr=DATA_ADDR -> RX_WAIT.
- RX_WAIT: load holding register with rdata[7:0]; m_rx_valid=1 from the next cycle. Set last=RX -> POLL.

TX stream handshake:
- s_tx_ready is only ever high in TX_WR.
- s_tx_valid must not be dropped by the source once asserted. If valid drops before TX_WR, the bridge re-evaluates on the next POLL and never writes stale data.

RX stream handshake:
- m_rx_valid stays high with m_rx_data stable until m_rx_ready.
- Transfer occurs on m_rx_valid && m_rx_ready. The holding register empties the next cycle.
- While the holding register is full, RX reads are suppressed; UART RX FIFO backpressure applies.

Boundary and timing rules:
- A TX FIFO full status blocks writes; no write is issued against a full FIFO.
- Throughput bound: one TX byte per 3 cycles (POLL, POLL_WAIT, TX_WR); one RX byte per 4 cycles.
- Status is always re-polled before each data access. The bridge never issues two data accesses back-to-back.
- Reset mid-operation: all strobes drop immediately (asynchronous). The init sequence reruns. Any RX byte in the holding register is discarded.

Test Plan:
- Reset release -> cycle 1: wr_en, addr=1, wdata=27. Cycle 2: wr_en, addr=0, wdata=1. init_done=1 at cycle 3. Then rd_en, addr=3.
- Idle UART model (status=0x4), s_tx_valid with bytes 0x55, 0xA3 -> DATA writes of 0x55 then 0xA3, each with s_tx_ready pulsed in the write cycle, 3 cycles apart.
- Status=0x2 (TX full) with s_tx_valid=1 for 20 cycles -> only status reads, no wr_en, s_tx_ready stays 0. Status=0x0 -> write issued.
- Model RX FIFO holding 0x41, 0x42, m_rx_ready=0 -> m_rx_valid=1 with data 0x41; no further DATA read. Assert m_rx_ready -> 0x42 follows.
- Both sides ready continuously -> accesses alternate RX, TX, RX, TX; no rd_en and wr_en overlap.
- Assert rst_n low during RX_WAIT -> outputs 0 asynchronously, m_rx_valid=0. On release, the init writes repeat.
